// File: rtl/reg_file_sb.sv
// =============================================================================
// Module      : reg_file_sb
// Description : 2R/1W register file with per-register pending scoreboard and
//               registered pending count. Optional macro: REGFILE_BYPASS_EN.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module reg_file_sb #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rd_addr1,
    input  logic [AW-1:0]   rd_addr2,
    output logic [XLEN-1:0] rd_data1,
    output logic [XLEN-1:0] rd_data2,
    output logic            busy1,
    output logic            busy2,
    input  logic            we,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            issue_en,
    input  logic [AW-1:0]   issue_addr,
    input  logic            flush,
    output logic [AW:0]     pend_cnt
);

    logic [XLEN-1:0] mem_q [NREG];
    logic [XLEN-1:0] mem_d [NREG];
    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_d;
    logic [AW:0]     pend_cnt_q;
    logic [AW:0]     pend_cnt_d;
    logic            wr_valid;
    logic            issue_valid;

    function automatic logic addr_valid(input logic [AW-1:0] a);
        return (int'(a) < NREG) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign wr_valid    = we && addr_valid(wr_addr);
    assign issue_valid = issue_en && addr_valid(issue_addr);

    // Write-clear first, then issue-set so a new producer wins; flush beats both.
    always_comb begin
        mem_d      = mem_q;
        pend_d     = pend_q;
        pend_cnt_d = '0;
        for (int i = 0; i < NREG; i++) begin
            if (wr_valid && (wr_addr == AW'(i))) begin
                mem_d[i]  = wr_data;
                pend_d[i] = 1'b0;
            end
            if (issue_valid && (issue_addr == AW'(i))) begin
                pend_d[i] = 1'b1;
            end
        end
        if (flush) begin
            pend_d = '0;
        end
        for (int i = 0; i < NREG; i++) begin
            pend_cnt_d = pend_cnt_d + (AW+1)'(pend_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
            pend_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            mem_q      <= mem_d;
            pend_q     <= pend_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    assign pend_cnt = pend_cnt_q;

    always_comb begin
        rd_data1 = '0;
        rd_data2 = '0;
        busy1    = 1'b0;
        busy2    = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (rd_addr1 == AW'(i)) begin
                rd_data1 = mem_q[i];
                busy1    = pend_q[i];
            end
            if (rd_addr2 == AW'(i)) begin
                rd_data2 = mem_q[i];
                busy2    = pend_q[i];
            end
        end
        if (!addr_valid(rd_addr1)) begin
            rd_data1 = '0;
            busy1    = 1'b0;
        end
        if (!addr_valid(rd_addr2)) begin
            rd_data2 = '0;
            busy2    = 1'b0;
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_valid && (wr_addr == rd_addr1)) begin
            rd_data1 = wr_data;
            busy1    = issue_valid && (issue_addr == rd_addr1);
        end
        if (wr_valid && (wr_addr == rd_addr2)) begin
            rd_data2 = wr_data;
            busy2    = issue_valid && (issue_addr == rd_addr2);
        end
`else
`endif
        // Outputs are held at zero for the whole time reset is asserted.
        if (!rst) begin
            rd_data1 = '0;
            rd_data2 = '0;
            busy1    = 1'b0;
            busy2    = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_reg_file_sb.sv
// =============================================================================
// Module      : tb_reg_file_sb
// Description : Self-checking bench for reg_file_sb (NREG=24) against an
//               array-based reference model; directed steps then random traffic.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_reg_file_sb;

    localparam int XLEN = 32;
    localparam int NREG = 24;
    localparam int AW   = 5;

    logic            clk;
    logic            rst;
    logic [AW-1:0]   rd_addr1;
    logic [AW-1:0]   rd_addr2;
    logic [XLEN-1:0] rd_data1;
    logic [XLEN-1:0] rd_data2;
    logic            busy1;
    logic            busy2;
    logic            we;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;
    logic            issue_en;
    logic [AW-1:0]   issue_addr;
    logic            flush;
    logic [AW:0]     pend_cnt;

    int checks   = 0;
    int failures = 0;

    logic [XLEN-1:0] m_regs [NREG];
    bit              m_pend [NREG];

    reg_file_sb #(.XLEN(XLEN), .NREG(NREG), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .busy1(busy1), .busy2(busy2),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .flush(flush), .pend_cnt(pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit vld(input int a);
        return (a < NREG) && (a != 0);
    endfunction

    function automatic int pend_count();
        int n = 0;
        for (int i = 0; i < NREG; i++) n += int'(m_pend[i]);
        return n;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
    endfunction

    function automatic void exp_read(input int a, output logic [XLEN-1:0] d, output logic b);
        d = vld(a) ? m_regs[a] : '0;
        b = vld(a) ? m_pend[a] : 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (we && vld(int'(wr_addr)) && int'(wr_addr) == a) begin
            d = wr_data;
            b = issue_en && vld(int'(issue_addr)) && int'(issue_addr) == a;
        end
`endif
        if (!rst) begin
            d = '0;
            b = 1'b0;
        end
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [XLEN-1:0] e1, e2;
        logic            b1, b2;
        #1;
        exp_read(int'(rd_addr1), e1, b1);
        exp_read(int'(rd_addr2), e2, b2);
        chk({tag, "_rd1"},  64'(rd_data1), 64'(e1));
        chk({tag, "_rd2"},  64'(rd_data2), 64'(e2));
        chk({tag, "_busy1"}, 64'(busy1), 64'(b1));
        chk({tag, "_busy2"}, 64'(busy2), 64'(b2));
        chk({tag, "_cnt"},  64'(pend_cnt), rst ? 64'(pend_count()) : 64'd0);
    endtask

    // One clock: model follows the inputs present at the edge, then controls drop.
    task automatic cyc();
        int wa = int'(wr_addr);
        int ia = int'(issue_addr);
        if (we && vld(wa)) begin
            m_regs[wa] = wr_data;
            m_pend[wa] = 1'b0;
        end
        if (issue_en && vld(ia)) m_pend[ia] = 1'b1;
        if (flush) for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
        @(posedge clk);
        #1;
        we       = 1'b0;
        issue_en = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic do_wr(input int a, input logic [XLEN-1:0] d);
        we = 1'b1; wr_addr = AW'(a); wr_data = d;
    endtask

    task automatic do_iss(input int a);
        issue_en = 1'b1; issue_addr = AW'(a);
    endtask

    task automatic rd(input int a1, input int a2);
        rd_addr1 = AW'(a1); rd_addr2 = AW'(a2);
    endtask

    initial begin
        rst = 1'b0; we = 1'b0; issue_en = 1'b0; flush = 1'b0;
        wr_addr = '0; wr_data = '0; issue_addr = '0; rd_addr1 = '0; rd_addr2 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Reset asserted mid-run after writes and issues
        do_wr(5, 32'hCAFE0005); do_iss(8); cyc();
        do_wr(3, 32'h00000033); cyc();
        rd(5, 8); check_all("pre_rst");
        chk("pre_rst_rd5", 64'(rd_data1), 64'h00000000CAFE0005);
        #2 rst = 1'b0;
        model_reset();
        rd(5, 3); check_all("in_rst");
        chk("in_rst_cnt", 64'(pend_cnt), 64'd0);
        @(posedge clk); #3 rst = 1'b1;
        rd(5, 8); check_all("post_rst");
        chk("post_rst_rd5", 64'(rd_data1), 64'd0);

        // Basic write, zero register
        do_wr(5, 32'hDEADBEEF); cyc();
        rd(5, 5); check_all("wr_r5");
        chk("wr_r5_const", 64'(rd_data2), 64'h00000000DEADBEEF);
        do_wr(0, 32'h1234); cyc();
        rd(0, 5); check_all("wr_r0");
        chk("wr_r0_const", 64'(rd_data1), 64'd0);

        // Issue, then writeback clears
        do_iss(3); cyc();
        do_iss(7); cyc();
        rd(3, 7); check_all("iss_3_7");
        chk("iss_cnt2", 64'(pend_cnt), 64'd2);
        do_wr(3, 32'h11); cyc();
        rd(3, 7); check_all("wb_r3");
        chk("wb_cnt1", 64'(pend_cnt), 64'd1);

        // Same-cycle write+issue, then flush with issue
        do_wr(9, 32'h55); do_iss(9); cyc();
        rd(9, 7); check_all("wr_iss_r9");
        chk("wr_iss_busy", 64'(busy1), 64'd1);
        chk("wr_iss_cnt", 64'(pend_cnt), 64'd2);
        flush = 1'b1; do_iss(4); do_wr(10, 32'h77); cyc();
        rd(4, 9); check_all("flush");
        chk("flush_cnt", 64'(pend_cnt), 64'd0);
        rd(10, 7); check_all("flush_wr");

        // Out-of-range address
        do_wr(30, 32'hBAD0BAD0); do_iss(30); cyc();
        rd(30, 31); check_all("oob");
        chk("oob_rd", 64'(rd_data1), 64'd0);

        // Same-cycle write and read of r6
        do_wr(6, 32'h00006666); cyc();
        do_wr(6, 32'hA5A5A5A5); rd(6, 6); check_all("same_cyc");
`ifdef REGFILE_BYPASS_EN
        chk("same_cyc_const", 64'(rd_data1), 64'h00000000A5A5A5A5);
`else
        chk("same_cyc_const", 64'(rd_data1), 64'h0000000000006666);
`endif
        cyc();
        rd(6, 6); check_all("after_same_cyc");

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            we         = 1'($urandom_range(0, 1));
            wr_addr    = AW'($urandom_range(0, 31));
            wr_data    = $urandom;
            issue_en   = 1'($urandom_range(0, 1));
            issue_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, 31));
            flush      = ($urandom_range(0, 15) == 0);
            rd_addr1   = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, 31));
            rd_addr2   = AW'($urandom_range(0, 31));
            check_all("rand");
            cyc();
        end
        rd(1, 2); check_all("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
